pc_stack_unit: RTL and testbench

//  Parametrised program-counter unit for the comp16 fetch stage: increment,

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_stack_unit_if.sv | 29 ++
 rtl/ret_stack.sv | 43 ++++
 rtl/pc_stack_unit.sv | 95 +++++++++
 tb/tb_pc_stack_unit.sv | 130 +++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared op-select codes and request priority encoder for the comp16 PC unit.
package pc_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'd0;
  localparam op_t OP_INCR = 3'd1;
  localparam op_t OP_JUMP = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_RET  = 3'd4;
  localparam op_t OP_IRQ  = 3'd5;

  // stall folds into HOLD so a stalled cycle touches no state at all
  function automatic op_t prio_enc(input logic stall, input logic irq,
                                   input logic ret, input logic call,
                                   input logic jump, input logic incr);
    op_t op;
    if (stall)     op = OP_HOLD;
    else if (irq)  op = OP_IRQ;
    else if (ret)  op = OP_RET;
    else if (call) op = OP_CALL;
    else if (jump) op = OP_JUMP;
    else if (incr) op = OP_INCR;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Request/status bundle between the fetch controller and the PC unit.
interface pc_stack_unit_if #(
  parameter int WIDTH = 16
);
  logic             stall;
  logic             incr;
  logic             jump;
  logic             cond_en;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] target;
  logic             call;
  logic             ret;
  logic             irq;
  logic [WIDTH-1:0] pc_out;
  logic             stack_full;
  logic             stack_empty;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output stall, incr, jump, cond_en, cond, target, call, ret, irq,
    input  pc_out, stack_full, stack_empty, err_ovf, err_unf
  );

  modport slave (
    input  stall, incr, jump, cond_en, cond, target, call, ret, irq,
    output pc_out, stack_full, stack_empty, err_ovf, err_unf
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO; the parent never asserts push and pop together.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = AW'(sp_q);
  assign rd_idx = AW'(sp_q - SPW'(1));
  assign dout   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full)      sp_d = sp_q + SPW'(1);
    else if (pop && !empty) sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem_q[wr_idx] <= din;
  end
endmodule

// File: rtl/pc_stack_unit.sv
// comp16 program counter: priority encode -> next-pc mux -> pc register, with
// a return-address stack for call/ret/irq and sticky stack error flags.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] IRQ_VEC   = WIDTH'(4)
) (
  input logic            clk,
  input logic            rst,
  pc_stack_unit_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] push_data, top;
  logic             full, empty, taken;
  op_t              op;

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );

  assign pc_inc = pc_q + WIDTH'(1);
  assign taken  = !bus.cond_en || (bus.cond != '0);
  assign op     = prio_enc(bus.stall, bus.irq, bus.ret, bus.call, bus.jump, bus.incr);

  always_comb begin
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    case (op)
      OP_IRQ: begin
        // the interrupted instruction has not executed yet, so save pc itself
        if (!full) begin
          push      = 1'b1;
          push_data = pc_q;
          pc_d      = IRQ_VEC;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!empty) begin
          pop  = 1'b1;
          pc_d = top;
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end
      OP_CALL: begin
        if (!full) begin
          push = 1'b1;
          pc_d = bus.target;
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_JUMP: pc_d = taken ? bus.target : pc_inc;
      OP_INCR: pc_d = pc_inc;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.err_ovf     = ovf_q;
  assign bus.err_unf     = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed scoreboard bench for pc_stack_unit (WIDTH=16, DEPTH=8).
module tb_pc_stack_unit;
  localparam logic [7:0] RST = 8'h01, STL = 8'h02, IRQ = 8'h04, RET = 8'h08,
                         CAL = 8'h10, JMP = 8'h20, CEN = 8'h40, INC = 8'h80;
  // flag order {empty, full, err_ovf, err_unf}
  localparam logic [3:0] F_E = 4'b1000, F_F = 4'b0100, F_O = 4'b0010, F_U = 4'b0001;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [3:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_stack_unit_if #(.WIDTH(16)) bus ();

  pc_stack_unit #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000), .IRQ_VEC(16'h0004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic [7:0] req, input logic [15:0] cnd,
                      input logic [15:0] tgt, input logic [15:0] exp_pc, input logic [3:0] exp_fl);
    exp_t e;
    rst         = req[0];
    bus.stall   = req[1];
    bus.irq     = req[2];
    bus.ret     = req[3];
    bus.call    = req[4];
    bus.jump    = req[5];
    bus.cond_en = req[6];
    bus.incr    = req[7];
    bus.cond    = cnd;
    bus.target  = tgt;
    @(posedge clk);
    e.name = nm;
    e.pc   = exp_pc;
    e.fl   = exp_fl;
    exp_q.push_back(e);
    #1;
  endtask

  // monitor: pc_out and flags are presented every cycle, compared on negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] got_fl;
      e = exp_q.pop_front();
      got_fl = {bus.stack_empty, bus.stack_full, bus.err_ovf, bus.err_unf};
      checks++;
      if (bus.pc_out !== e.pc) begin
        errors++;
        $display("FAIL %s pc_out got %h want %h", e.name, bus.pc_out, e.pc);
      end
      checks++;
      if (got_fl !== e.fl) begin
        errors++;
        $display("FAIL %s flags(e,f,o,u) got %b want %b", e.name, got_fl, e.fl);
      end
    end
  end

  initial begin
    int wait_cyc;
    step("reset", RST, 16'h0, 16'h0, 16'h0000, F_E);
    step("incr1", INC, 16'h0, 16'h0, 16'h0001, F_E);
    step("incr2", INC, 16'h0, 16'h0, 16'h0002, F_E);
    step("incr3", INC, 16'h0, 16'h0, 16'h0003, F_E);

    step("jmp_to10",  JMP,       16'h0000, 16'h0010, 16'h0010, F_E);
    step("jc_ntaken", JMP | CEN, 16'h0000, 16'h0100, 16'h0011, F_E);
    step("jc_taken",  JMP | CEN, 16'h0004, 16'h0100, 16'h0100, F_E);
    step("j_uncond",  JMP,       16'h0000, 16'h0200, 16'h0200, F_E);

    step("jmp_to20", JMP, 16'h0, 16'h0020, 16'h0020, F_E);
    step("call300",  CAL, 16'h0, 16'h0300, 16'h0300, 4'b0);
    step("call400",  CAL, 16'h0, 16'h0400, 16'h0400, 4'b0);
    step("ret1",     RET, 16'h0, 16'h0000, 16'h0301, 4'b0);
    step("ret2",     RET, 16'h0, 16'h0000, 16'h0021, F_E);
    step("ret_unf",  RET, 16'h0, 16'h0000, 16'h0022, F_E | F_U);

    for (int i = 0; i < 8; i++)
      step("fill_call", CAL, 16'h0, 16'h1000 + 16'(i), 16'h1000 + 16'(i),
           F_U | ((i == 7) ? F_F : 4'b0));
    step("call_ovf", CAL, 16'h0, 16'h2000, 16'h1007, F_F | F_O | F_U);
    step("irq_full", IRQ, 16'h0, 16'h0000, 16'h1007, F_F | F_O | F_U);
    for (int i = 7; i >= 1; i--)
      step("drain_ret", RET, 16'h0, 16'h0, 16'h1000 + 16'(i), F_O | F_U);
    step("drain_last", RET, 16'h0, 16'h0, 16'h0023, F_E | F_O | F_U);

    step("jmp_to50", JMP,             16'h0, 16'h0050, 16'h0050, F_E | F_O | F_U);
    step("irq_mix",  IRQ | CAL | INC, 16'h0, 16'h0900, 16'h0004, F_O | F_U);
    step("ret_irq",  RET,             16'h0, 16'h0000, 16'h0050, F_E | F_O | F_U);

    step("jmp_ffff", JMP, 16'h0, 16'hFFFF, 16'hFFFF, F_E | F_O | F_U);
    step("wrap",     INC, 16'h0, 16'h0000, 16'h0000, F_E | F_O | F_U);
    step("call500",  CAL, 16'h0, 16'h0500, 16'h0500, F_O | F_U);
    step("call600",  CAL, 16'h0, 16'h0600, 16'h0600, F_O | F_U);
    step("call700",  CAL, 16'h0, 16'h0700, 16'h0700, F_O | F_U);
    step("stall_call", STL | CAL, 16'h0, 16'h0800, 16'h0700, F_O | F_U);
    step("stall_ret",  STL | RET, 16'h0, 16'h0000, 16'h0700, F_O | F_U);
    step("rst_stall",  RST | STL | CAL, 16'h0, 16'h0800, 16'h0000, F_E);
    step("post_rst",   INC, 16'h0, 16'h0000, 16'h0001, F_E);
    step("hold",       8'h00, 16'h0, 16'h0000, 16'h0001, F_E);
    step("call300b",   CAL, 16'h0, 16'h0300, 16'h0300, 4'b0);
    step("ret_prio",   RET | CAL | JMP, 16'h0, 16'h0999, 16'h0002, F_E);
    step("idle", 8'h00, 16'h0, 16'h0, 16'h0002, F_E);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
